// File: rtl/bnn_pkg.sv
// Shared types and elaboration-time width helpers for the rolled BNN classifier.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIDDEN,
    CLASS,
    DONE
  } state_t;

  // Signed accumulator width for one hidden neuron; wide enough for +/- FEAT_CNT full-scale features.
  function automatic int unsigned acc_width(input int unsigned feat_bits, input int unsigned feat_cnt);
    return feat_bits + $clog2(feat_cnt) + 2;
  endfunction

  // Width of a class agreement score in the range 0..hidden_cnt.
  function automatic int unsigned score_width(input int unsigned hidden_cnt);
    return $clog2(hidden_cnt + 1);
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/bnn_neuron_chunk.sv
// Combinational evaluation of PAR binary hidden neurons against the latched feature vector.
module bnn_neuron_chunk
  import bnn_pkg::*;
#(
  parameter int unsigned FEAT_CNT  = 12,
  parameter int unsigned FEAT_BITS = 4,
  parameter int unsigned PAR       = 8
) (
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features_i,
  input  logic [PAR*FEAT_CNT-1:0]       weights_i,
  input  logic [PAR-1:0]                mask_i,
  output logic [PAR-1:0]                hid_o
);

  localparam int unsigned AW = acc_width(FEAT_BITS, FEAT_CNT);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] x;

  // Signed sum of +/- features per neuron; a neuron fires when its sum is non-negative.
  always_comb begin
    hid_o = '0;
    acc   = '0;
    x     = '0;
    for (int unsigned p = 0; p < PAR; p++) begin
      acc = '0;
      for (int unsigned f = 0; f < FEAT_CNT; f++) begin
        x = AW'(features_i[f*FEAT_BITS +: FEAT_BITS]);
        if (weights_i[p*FEAT_CNT + f]) acc = acc + x;
        else                           acc = acc - x;
      end
      hid_o[p] = mask_i[p] & ~acc[AW-1];
    end
  end

endmodule

// File: rtl/bnn_roll_stream.sv
// Rolled two-layer BNN classifier with valid/ready streams and PAR hidden neurons per cycle.
module bnn_roll_stream
  import bnn_pkg::*;
#(
  parameter int unsigned FEAT_CNT   = 12,
  parameter int unsigned FEAT_BITS  = 4,
  parameter int unsigned HIDDEN_CNT = 40,
  parameter int unsigned CLASS_CNT  = 6,
  parameter int unsigned PAR        = 8,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  Weights0 = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] Weights1 = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]    features,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]     prediction,
  output logic                             busy
);

  localparam int unsigned NH    = ceil_div(HIDDEN_CNT, PAR);
  localparam int unsigned CHW   = (NH > 1) ? $clog2(NH) : 1;
  localparam int unsigned CLW   = $clog2(CLASS_CNT);
  localparam int unsigned SW    = score_width(HIDDEN_CNT);
  localparam int unsigned HPAD  = NH * PAR;
  localparam int unsigned WSL   = PAR * FEAT_CNT;
  localparam int unsigned W0PW  = HPAD * FEAT_CNT;
  // Zero-padded so the last partial chunk can use a full-width slice; padded neurons are masked off.
  localparam logic [W0PW-1:0] W0_PAD = W0PW'(Weights0);

  state_t                          state_q;
  logic [FEAT_CNT*FEAT_BITS-1:0]   feat_q;
  logic [HPAD-1:0]                 hid_q;
  logic [CHW-1:0]                  chunk_q;
  logic [CLW-1:0]                  cls_q;
  logic [SW-1:0]                   max_q;
  logic [CLW-1:0]                  best_q;
  logic                            out_valid_q;
  logic [CLW-1:0]                  pred_q;

  logic [31:0]                     chunk_idx;
  logic [31:0]                     cls_idx;
  logic [WSL-1:0]                  w_slice;
  logic [PAR-1:0]                  mask;
  logic [PAR-1:0]                  chunk_hid;
  logic [HPAD-1:0]                 hid_d;
  logic [HIDDEN_CNT-1:0]           row;
  logic [HIDDEN_CNT-1:0]           agree;
  logic [SW-1:0]                   score;
  logic                            take;
  logic                            accept;

  assign chunk_idx  = 32'(chunk_q);
  assign cls_idx    = 32'(cls_q);
  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q == HIDDEN) || (state_q == CLASS);
  assign out_valid  = out_valid_q;
  assign prediction = pred_q;

  bnn_neuron_chunk #(
    .FEAT_CNT  (FEAT_CNT),
    .FEAT_BITS (FEAT_BITS),
    .PAR       (PAR)
  ) u_chunk (
    .features_i (feat_q),
    .weights_i  (w_slice),
    .mask_i     (mask),
    .hid_o      (chunk_hid)
  );

  // Select the current chunk's weights, mask neurons past HIDDEN_CNT, and merge results into the hidden vector.
  always_comb begin
    w_slice = W0_PAD[chunk_idx*WSL +: WSL];
    mask    = '0;
    for (int unsigned p = 0; p < PAR; p++) begin
      mask[p] = (chunk_idx*PAR + p) < HIDDEN_CNT;
    end
    hid_d = hid_q;
    hid_d[chunk_idx*PAR +: PAR] = (hid_q[chunk_idx*PAR +: PAR] & ~mask) | (chunk_hid & mask);
  end

  // XNOR-popcount score for the current class and strict-greater comparison against the running max.
  always_comb begin
    row   = Weights1[cls_idx*HIDDEN_CNT +: HIDDEN_CNT];
    agree = ~(hid_q[HIDDEN_CNT-1:0] ^ row);
    score = '0;
    for (int unsigned h = 0; h < HIDDEN_CNT; h++) begin
      score = score + SW'(agree[h]);
    end
    take = (cls_q == '0) || (score > max_q);
  end

  // Control FSM with registered handshake outputs, counters and argmax state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      feat_q      <= '0;
      hid_q       <= '0;
      chunk_q     <= '0;
      cls_q       <= '0;
      max_q       <= '0;
      best_q      <= '0;
      out_valid_q <= 1'b0;
      pred_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            feat_q  <= features;
            chunk_q <= '0;
            state_q <= HIDDEN;
          end
        end
        HIDDEN: begin
          hid_q <= hid_d;
          if (chunk_q == CHW'(NH - 1)) begin
            chunk_q <= '0;
            cls_q   <= '0;
            state_q <= CLASS;
          end else begin
            chunk_q <= chunk_q + 1'b1;
          end
        end
        CLASS: begin
          if (take) begin
            max_q  <= score;
            best_q <= cls_q;
          end
          if (cls_q == CLW'(CLASS_CNT - 1)) begin
            pred_q      <= take ? cls_q : best_q;
            out_valid_q <= 1'b1;
            cls_q       <= '0;
            state_q     <= DONE;
          end else begin
            cls_q <= cls_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              feat_q  <= features;
              chunk_q <= '0;
              state_q <= HIDDEN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_roll_stream.sv
// Self-checking bench: four configurations, table-driven vectors and a per-instance result scoreboard.
module tb_bnn_roll_stream;
  import bnn_pkg::*;

  localparam logic [7:0]   W0_A = 8'h2D;
  localparam logic [11:0]  W1_A = 12'hF30;
  localparam logic [7:0]   W0_D = 8'hFF;
  localparam logic [11:0]  W1_D = 12'h000;
  localparam logic [479:0] W0_B = {16{30'h2B3C_5A17}};
  localparam logic [239:0] W1_B = {8{30'h1F0A_3C65}};
  localparam logic [59:0]  W0_C = {2{30'h3A5C_96E1}};
  localparam logic [29:0]  W1_C = 30'h2E61_D4B9;

  logic clk, rst;
  logic iv_s, ordy_s, iv_l, ordy_l;
  logic [7:0]  feat_s;
  logic [47:0] feat_l;
  logic rdy_a, ov_a, busy_a, rdy_d, ov_d, busy_d;
  logic rdy_b, ov_b, busy_b, rdy_c, ov_c, busy_c;
  logic [1:0] pred_a, pred_d;
  logic [2:0] pred_b, pred_c;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned qa[$], qb[$], qc[$], qd[$];

  bnn_roll_stream #(.FEAT_CNT(2), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(2),
                    .Weights0(W0_A), .Weights1(W1_A)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(rdy_a), .features(feat_s),
    .out_valid(ov_a), .out_ready(ordy_s), .prediction(pred_a), .busy(busy_a));

  bnn_roll_stream #(.FEAT_CNT(2), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(2),
                    .Weights0(W0_D), .Weights1(W1_D)) dut_d (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(rdy_d), .features(feat_s),
    .out_valid(ov_d), .out_ready(ordy_s), .prediction(pred_d), .busy(busy_d));

  bnn_roll_stream #(.Weights0(W0_B), .Weights1(W1_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_l), .in_ready(rdy_b), .features(feat_l),
    .out_valid(ov_b), .out_ready(ordy_l), .prediction(pred_b), .busy(busy_b));

  bnn_roll_stream #(.HIDDEN_CNT(5), .PAR(2), .Weights0(W0_C), .Weights1(W1_C)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv_l), .in_ready(rdy_c), .features(feat_l),
    .out_valid(ov_c), .out_ready(ordy_l), .prediction(pred_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference classifier: straightforward sums and argmax with lowest-index tie break.
  function automatic int unsigned model(input logic [63:0] feat, input int unsigned fc,
                                        input int unsigned fb, input int unsigned hc,
                                        input int unsigned cc, input logic [511:0] w0,
                                        input logic [255:0] w1);
    int acc, x, s, bmax;
    int unsigned best;
    logic [63:0] hid;
    hid = '0; best = 0; bmax = -1;
    for (int unsigned h = 0; h < hc; h++) begin
      acc = 0;
      for (int unsigned f = 0; f < fc; f++) begin
        x = int'((feat >> (f*fb)) & ((64'd1 << fb) - 64'd1));
        acc = w0[h*fc + f] ? acc + x : acc - x;
      end
      hid[h] = (acc >= 0);
    end
    for (int unsigned c = 0; c < cc; c++) begin
      s = 0;
      for (int unsigned h = 0; h < hc; h++) if (hid[h] == w1[c*hc + h]) s++;
      if (s > bmax) begin bmax = s; best = c; end
    end
    return best;
  endfunction

  // Scoreboard monitors: compare each handed-off prediction against the oldest expected value.
  always @(negedge clk) if (!rst && ov_a && ordy_s) begin
    if (qa.size() == 0) check("spurious_a", ov_a, 0);
    else check("pred_a", pred_a, qa.pop_front());
  end
  always @(negedge clk) if (!rst && ov_d && ordy_s) begin
    if (qd.size() == 0) check("spurious_d", ov_d, 0);
    else check("pred_d", pred_d, qd.pop_front());
  end
  always @(negedge clk) if (!rst && ov_b && ordy_l) begin
    if (qb.size() == 0) check("spurious_b", ov_b, 0);
    else check("pred_b", pred_b, qb.pop_front());
  end
  always @(negedge clk) if (!rst && ov_c && ordy_l) begin
    if (qc.size() == 0) check("spurious_c", ov_c, 0);
    else check("pred_c", pred_c, qc.pop_front());
  end

  task automatic issue_s(input logic [7:0] f);
    @(posedge clk); #1;
    feat_s = f; iv_s = 1'b1;
    @(posedge clk); #1;
    iv_s = 1'b0;
  endtask

  task automatic issue_l(input logic [47:0] f);
    @(posedge clk); #1;
    feat_l = f; iv_l = 1'b1;
    @(posedge clk); #1;
    iv_l = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (qa.size() + qb.size() + qc.size() + qd.size() == 0) break;
      @(negedge clk);
    end
    check(name, 64'(qa.size() + qb.size() + qc.size() + qd.size()), 0);
  endtask

  typedef struct {
    logic [7:0]  feat;
    int unsigned exp_a;
    int unsigned exp_d;
    logic [3:0]  hid;
    logic        hid_chk;
  } vec_s_t;

  typedef struct {
    logic [47:0] feat;
    int unsigned exp_b;
    int unsigned exp_c;
  } vec_l_t;

  vec_s_t tab_s[5];
  vec_l_t tab_l[5];

  initial begin
    rst = 1'b1; iv_s = 1'b0; ordy_s = 1'b1; feat_s = '0;
    iv_l = 1'b0; ordy_l = 1'b1; feat_l = '0;

    // Hand-derived small-config vectors: sign rule, all-ones hidden, ties.
    tab_s[0] = '{8'h53, 0, 0, 4'b0110, 1'b1};
    tab_s[1] = '{8'h00, 2, 0, 4'b1111, 1'b1};
    tab_s[2] = '{8'hFF, 1, 0, 4'b0111, 1'b1};
    tab_s[3] = '{8'h0A, 1, 0, 4'b0011, 1'b1};
    tab_s[4].feat    = 8'($urandom);
    tab_s[4].exp_a   = model(64'(tab_s[4].feat), 2, 4, 4, 3, 512'(W0_A), 256'(W1_A));
    tab_s[4].exp_d   = 0;
    tab_s[4].hid     = '0;
    tab_s[4].hid_chk = 1'b0;

    tab_l[0].feat = '0;
    tab_l[1].feat = '1;
    tab_l[2].feat = 48'h0123_4567_89AB;
    tab_l[3].feat = 48'hFEDC_BA98_7654;
    tab_l[4].feat = {16'($urandom), 32'($urandom)};
    for (int i = 0; i < 5; i++) begin
      tab_l[i].exp_b = model(64'(tab_l[i].feat), 12, 4, 40, 6, 512'(W0_B), 256'(W1_B));
      tab_l[i].exp_c = model(64'(tab_l[i].feat), 12, 4, 5, 6, 512'(W0_C), 256'(W1_C));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {ov_a, ov_b, ov_c, ov_d}, 0);
    check("rst_prediction", {pred_a, pred_b, pred_c, pred_d}, 0);
    check("rst_in_ready", {rdy_a, rdy_b, rdy_c, rdy_d}, 4'hF);
    check("rst_busy", {busy_a, busy_b, busy_c, busy_d}, 0);
    rst = 1'b0;

    // Small configurations, one inference at a time.
    for (int i = 0; i < 5; i++) begin
      qa.push_back(tab_s[i].exp_a);
      qd.push_back(tab_s[i].exp_d);
      issue_s(tab_s[i].feat);
      drain("drain_s");
      if (tab_s[i].hid_chk) check("hid_a", dut_a.hid_q[3:0], tab_s[i].hid);
    end

    // Default latency on B, partial-chunk latency on C, then backpressure.
    ordy_l = 1'b0;
    qb.push_back(tab_l[2].exp_b);
    qc.push_back(tab_l[2].exp_c);
    issue_l(tab_l[2].feat);
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check("lat_ov_b", ov_b, k == 11);
      check("lat_busy_b", busy_b, k < 11);
      check("lat_rdy_b", rdy_b, 0);
      check("lat_ov_c", ov_c, k >= 9);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check("bp_ov_b", ov_b, 1);
      check("bp_pred_b", pred_b, tab_l[2].exp_b);
      check("bp_rdy_b", rdy_b, 0);
      check("bp_pred_c", pred_c, tab_l[2].exp_c);
    end

    // Release and issue the next inference on the same edge.
    qb.push_back(tab_l[3].exp_b);
    qc.push_back(tab_l[3].exp_c);
    @(posedge clk); #1;
    ordy_l = 1'b1; iv_l = 1'b1; feat_l = tab_l[3].feat;
    #1;
    check("b2b_rdy_b", rdy_b, 1);
    @(posedge clk); #1;
    iv_l = 1'b0;
    check("b2b_ov_b", ov_b, 0);
    check("b2b_busy_b", busy_b, 1);
    check("b2b_ov_c", ov_c, 0);
    check("b2b_busy_c", busy_c, 1);
    drain("drain_b2b");

    for (int i = 0; i < 5; i++) begin
      qb.push_back(tab_l[i].exp_b);
      qc.push_back(tab_l[i].exp_c);
      issue_l(tab_l[i].feat);
      drain("drain_l");
    end

    // Reset during CLASS aborts the inference; a following one still completes.
    qa.push_back(2);
    qd.push_back(0);
    issue_s(8'h00);
    drain("drain_pre_rst");
    issue_s(8'hFF);
    repeat (3) begin @(posedge clk); #1; end
    check("mid_state_class", dut_a.state_q, CLASS);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_state", dut_a.state_q, IDLE);
    check("mid_rst_ov", ov_a, 0);
    check("mid_rst_pred", pred_a, 0);
    check("mid_rst_rdy", rdy_a, 1);
    repeat (15) @(posedge clk);
    #1;
    check("mid_rst_no_out", {ov_a, ov_d}, 0);
    qa.push_back(1);
    qd.push_back(0);
    issue_s(8'hFF);
    drain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bnn_roll_stream.md
Name: bnn_roll_stream

Overview:
- Parametrised successor to the rolled two-layer BNN classifier.
- Adds a valid/ready stream interface on features and prediction, and configurable hidden-layer parallelism: PAR neurons are evaluated per cycle.
- Sits between the feature quantiser and the result sink. Weights are elaboration-time constants.
- One inference is in flight at a time. Back-to-back issue is supported at the DONE→accept boundary.

Parameters:
- FEAT_CNT, 12: number of input features.
- FEAT_BITS, 4: unsigned width of each feature.
- HIDDEN_CNT, 40: hidden binary neurons.
- CLASS_CNT, 6: output classes, must be ≥2.
- PAR, 8: hidden neurons evaluated per cycle, 1..HIDDEN_CNT.
- Weights0, 0: FEAT_CNT*HIDDEN_CNT bits. Bit h*FEAT_CNT+f is the weight from feature f to neuron h.
- Weights1, 0: HIDDEN_CNT*CLASS_CNT bits. Bit c*HIDDEN_CNT+h is the weight from neuron h to class c.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: features are valid.
- in_ready, output, 1: block can accept features.
- features, input, FEAT_CNT*FEAT_BITS: feature f is features[f*FEAT_BITS +: FEAT_BITS], unsigned.
- out_valid, output, 1: prediction is valid.
- out_ready, input, 1: sink accepts the prediction.
- prediction, output, $clog2(CLASS_CNT): winning class index.
- busy, output, 1: high in HIDDEN or CLASS state.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state←IDLE; out_valid←0; prediction←0.
  - Hidden register, chunk counter, class counter and running max all ←0.
  - Reset mid-inference aborts the inference; no out_valid is produced.
- States and transitions: IDLE → HIDDEN → CLASS → DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept occurs when in_valid && in_ready.
- IDLE: on accept, latch features, chunk←0, go to HIDDEN.
- HIDDEN: lasts NH = ceil(HIDDEN_CNT/PAR) cycles, one cycle per chunk.
  - Chunk k evaluates neurons k*PAR .. k*PAR+PAR-1.
  - Neurons with index ≥ HIDDEN_CNT in the last partial chunk are ignored and never written.
  - Neuron h: acc_h = Σ_f (W0 bit ? +x_f : −x_f). Signed width is FEAT_BITS+$clog2(FEAT_CNT)+2; no overflow is allowed.
  - hid[h] = (acc_h ≥ 0).
  - After the last chunk, cls←0 and go to CLASS.
- CLASS: lasts CLASS_CNT cycles, one class per cycle.
  - score_c = popcount(~(hid ^ W1 row c)); width $clog2(HIDDEN_CNT+1).
  - Class 0 initialises the running max.
  - Class c>0 replaces the running max only if score_c > max (strict). Ties therefore resolve to the lowest index.
  - After the last class, prediction←argmax, out_valid←1, go to DONE.
- DONE:
  - out_valid and prediction are held stable until out_ready is seen.
  - out_ready=1 and in_valid=0: go to IDLE, out_valid←0.
  - out_ready=1 and in_valid=1: accept the new features in the same cycle, go to HIDDEN, out_valid←0.
- Latency: with the accept edge as edge 0, out_valid rises after edge NH+CLASS_CNT. Defaults: 5+6 = 11 edges.
- in_valid while busy is ignored; features are not re-sampled.
- out_ready while out_valid=0 has no effect.
- busy = (state==HIDDEN || state==CLASS).

Decomposition:
- Package bnn_pkg holds:
  - state enum {IDLE, HIDDEN, CLASS, DONE};
  - width functions acc_width(FEAT_BITS, FEAT_CNT) and score_width(HIDDEN_CNT);
  - function ceil_div.
- Sub-module bnn_neuron_chunk: combinational, PAR neurons. Inputs are features, a PAR*FEAT_CNT weight slice and a valid mask; output is PAR hidden bits.
- The top level owns the FSM, counters, hidden register, popcount/argmax datapath and handshake.

Test Plan:
- Sign rule. Config FEAT_CNT=2, HIDDEN_CNT=4, CLASS_CNT=3, PAR=2. Neuron 0 weights f0=1, f1=0; x0=3, x1=5 → acc=−2 → hid[0]=0. All-zero features → every hid bit=1 (acc=0 counts as ≥0).
- Argmax and tie.
  - Same config, W0 all ones, features 0 → hid=1111. W1 rows c0=0000, c1=0011, c2=1111 → prediction=2.
  - W1 all zero → all scores 0 → prediction=0.
- Default latency. Default parameters, in_valid pulsed at edge 0 → in_ready=0 and busy=1 during edges 1–11; out_valid rises after edge 11 exactly.
- Partial chunk. HIDDEN_CNT=5, PAR=2 → NH=3. Result matches the reference model; out_valid rises after edge 3+CLASS_CNT.
- Backpressure and back-to-back.
  - out_ready=0 for 20 cycles → out_valid=1, prediction stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 in the same cycle → new features accepted, out_valid drops next cycle, second result correct.
- Reset mid-op. Assert rst during CLASS → next cycle state=IDLE, out_valid=0, prediction=0, in_ready=1. A following inference is correct.
